// File: rtl/media_notas_if.sv
// media_notas_if
// Groups the grade-entry controls and the averaging results into one bundle.
//   master : the switch/button side. It drives nota_in, enter and clear, and it
//            observes media, media_valid, count, busy and erro.
//   slave  : the averaging block. It takes the controls and drives the results.
interface media_notas_if;
  logic [3:0] nota_in;
  logic       enter;
  logic       clear;
  logic [3:0] media;
  logic       media_valid;
  logic [3:0] count;
  logic       busy;
  logic       erro;

  modport master (
    output nota_in, enter, clear,
    input  media, media_valid, count, busy, erro
  );

  modport slave (
    input  nota_in, enter, clear,
    output media, media_valid, count, busy, erro
  );
endinterface

// File: rtl/media_notas.sv
// media_notas
// Collects NUM_NOTAS grades from the switches, one per rising edge of enter.
// When the last grade is accepted, it produces the rounded average.
// Ports:
//   clk_2  - single clock, active on the rising edge
//   reset  - asynchronous, active-high reset
//   nif    - slave side of media_notas_if:
//            nota_in / enter / clear in,
//            media / media_valid / count / busy / erro out
//
// state   | meaning
// IDLE    | no grade accepted yet
// COLLECT | at least one grade accepted, average not complete
// DONE    | average registered on media, further entries ignored
module media_notas #(
  parameter int NUM_NOTAS = 4,
  parameter int NOTA_MAX  = 10
) (
  input  logic            clk_2,
  input  logic            reset,
  media_notas_if.slave    nif
);

  localparam int         LOG2     = $clog2(NUM_NOTAS);
  localparam logic [4:0] NOTA_LIM = 5'(NOTA_MAX);
  localparam logic [3:0] CNT_LAST = 4'(NUM_NOTAS);
  localparam logic [7:0] HALF     = 8'(NUM_NOTAS / 2);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t     state, state_nxt;
  logic       enter_q;
  logic [6:0] sum, sum_nxt;
  logic [3:0] count, count_nxt;
  logic [3:0] media, media_nxt;
  logic       media_valid, media_valid_nxt;
  logic       erro, erro_nxt;

  logic       entry_evt;
  logic [6:0] sum_add;
  logic [3:0] count_inc;
  logic [7:0] rnd;

  assign entry_evt = nif.enter & ~enter_q;
  assign sum_add   = sum + {3'b000, nif.nota_in};
  assign count_inc = count + 4'd1;
  // Round half up: add half the divisor before shifting.
  assign rnd       = {1'b0, sum_add} + HALF;

  // enter_q resets high, so an enter held high across reset release
  // does not look like a rising edge.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      enter_q     <= 1'b1;
      sum         <= '0;
      count       <= '0;
      media       <= '0;
      media_valid <= 1'b0;
      erro        <= 1'b0;
    end else begin
      state       <= state_nxt;
      enter_q     <= nif.enter;
      sum         <= sum_nxt;
      count       <= count_nxt;
      media       <= media_nxt;
      media_valid <= media_valid_nxt;
      erro        <= erro_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    sum_nxt         = sum;
    count_nxt       = count;
    media_nxt       = media;
    media_valid_nxt = media_valid;
    erro_nxt        = 1'b0;

    if (nif.clear) begin
      // clear takes priority over a coincident entry, and that grade is lost.
      state_nxt       = IDLE;
      sum_nxt         = '0;
      count_nxt       = '0;
      media_nxt       = '0;
      media_valid_nxt = 1'b0;
    end else begin
      unique case (state)
        IDLE, COLLECT: begin
          if (entry_evt) begin
            if ({1'b0, nif.nota_in} > NOTA_LIM) begin
              erro_nxt = 1'b1;
            end else begin
              sum_nxt   = sum_add;
              count_nxt = count_inc;
              if (count_inc == CNT_LAST) begin
                state_nxt       = DONE;
                media_nxt       = rnd[LOG2 +: 4];
                media_valid_nxt = 1'b1;
              end else begin
                state_nxt = COLLECT;
              end
            end
          end
        end
        DONE: ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign nif.media       = media;
  assign nif.media_valid = media_valid;
  assign nif.count       = count;
  assign nif.busy        = (state == COLLECT);
  assign nif.erro        = erro;

endmodule
